// File: rtl/drug_delivery_controller.sv
// ---------------------------------------------------------------------------
// drug_delivery_controller
//
// Turns dose requests from the heart monitor into metered infusion-pump step
// pulses. Handles pump flow control (pump_ready), a post-dose lockout, a
// per-session dose limit and occlusion faults.
//
// Optional feature: define DELIVERY_WATCHDOG_EN to add a stall watchdog.
// While delivering, it faults after WATCHDOG_CYCLES consecutive cycles in
// which a step is due but pump_ready is low.
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    synchronous active-high reset
//   drug_delivery_activate dose request level; its rising edge is a request
//   drug_dosage[3:0]       dose size in units, sampled on the request edge
//   pump_ready             pump can accept a step
//   occlusion              line-occlusion sensor, active high
//   fault_clear            one-cycle pulse that clears a fault
//   pump_step              one-cycle step pulse to the pump
//   busy                   high while delivering or in lockout
//   dose_done              one-cycle pulse coincident with the last step
//   fault                  sticky fault flag
//   limit_reached          dose_count has hit MAX_DOSES
//   dose_count[3:0]        completed doses, saturating at MAX_DOSES
// ---------------------------------------------------------------------------
module drug_delivery_controller #(
  parameter int STEPS_PER_UNIT  = 4,
  parameter int STEP_PERIOD     = 8,
  parameter int LOCKOUT_CYCLES  = 64,
  parameter int MAX_DOSES       = 8,
  parameter int WATCHDOG_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       drug_delivery_activate,
  input  logic [3:0] drug_dosage,
  input  logic       pump_ready,
  input  logic       occlusion,
  input  logic       fault_clear,
  output logic       pump_step,
  output logic       busy,
  output logic       dose_done,
  output logic       fault,
  output logic       limit_reached,
  output logic [3:0] dose_count
);

  localparam int REM_W = 4 + $clog2(STEPS_PER_UNIT) + 1;
  localparam int TMR_W = $clog2(STEP_PERIOD);
  localparam int LCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  if (STEP_PERIOD < 2 || WATCHDOG_CYCLES < 1) begin : g_param_check
    $error("drug_delivery_controller: STEP_PERIOD must be >= 2 and WATCHDOG_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELIVER,
    S_LOCKOUT,
    S_FAULT
  } state_t;

  state_t           state;
  logic             act_d;
  logic [REM_W-1:0] remaining;
  logic [TMR_W-1:0] timer;
  logic [LCK_W-1:0] lock_cnt;
  logic             req_edge;
  logic             at_terminal;

`ifdef DELIVERY_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;
`endif

  // Saturating increment of the completed-dose counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt >= 4'(MAX_DOSES)) return cnt;
    else                      return cnt + 4'd1;
  endfunction

  assign req_edge      = drug_delivery_activate & ~act_d;
  assign at_terminal   = (timer == TMR_W'(STEP_PERIOD - 1));
  assign limit_reached = (dose_count == 4'(MAX_DOSES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      act_d      <= 1'b0;
      remaining  <= '0;
      timer      <= '0;
      lock_cnt   <= '0;
      pump_step  <= 1'b0;
      busy       <= 1'b0;
      dose_done  <= 1'b0;
      fault      <= 1'b0;
      dose_count <= 4'd0;
`ifdef DELIVERY_WATCHDOG_EN
      wd_cnt     <= '0;
`endif
    end else begin
      act_d     <= drug_delivery_activate;
      pump_step <= 1'b0;
      dose_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (occlusion) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else if (req_edge && drug_dosage != 4'd0 && !limit_reached && !fault) begin
            state     <= S_DELIVER;
            remaining <= REM_W'(drug_dosage) * REM_W'(STEPS_PER_UNIT);
            timer     <= '0;
            busy      <= 1'b1;
`ifdef DELIVERY_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end
        end

        S_DELIVER: begin
          // Occlusion outranks a due step, including the final one.
          if (occlusion) begin
            state     <= S_FAULT;
            fault     <= 1'b1;
            busy      <= 1'b0;
            remaining <= '0;
            timer     <= '0;
          end else if (at_terminal && pump_ready) begin
            pump_step <= 1'b1;
            remaining <= remaining - REM_W'(1);
            timer     <= '0;
`ifdef DELIVERY_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
            if (remaining == REM_W'(1)) begin
              state      <= S_LOCKOUT;
              lock_cnt   <= '0;
              dose_done  <= 1'b1;
              dose_count <= sat_inc(dose_count);
            end
          end else if (!at_terminal) begin
            timer <= timer + TMR_W'(1);
`ifdef DELIVERY_WATCHDOG_EN
          end else if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
            // Pump stalled too long: treated exactly like an occlusion.
            state     <= S_FAULT;
            fault     <= 1'b1;
            busy      <= 1'b0;
            remaining <= '0;
            timer     <= '0;
            wd_cnt    <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
`endif
          end
        end

        S_LOCKOUT: begin
          // Requests are not latched here; act_d keeps tracking the input so
          // a level held through lockout never counts as a new edge.
          if (occlusion) begin
            state <= S_FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else if (lock_cnt == LCK_W'(LOCKOUT_CYCLES - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + LCK_W'(1);
          end
        end

        S_FAULT: begin
          if (fault_clear && !occlusion) begin
            state <= S_IDLE;
            fault <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drug_delivery_controller.sv
// ---------------------------------------------------------------------------
// tb_drug_delivery_controller
//
// Directed bench for drug_delivery_controller with default parameters
// (4 steps/unit, 8-cycle step period, 64-cycle lockout, 8 doses max).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, so each sample reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_drug_delivery_controller;

  logic       clk;
  logic       rst;
  logic       drug_delivery_activate;
  logic [3:0] drug_dosage;
  logic       pump_ready;
  logic       occlusion;
  logic       fault_clear;
  logic       pump_step;
  logic       busy;
  logic       dose_done;
  logic       fault;
  logic       limit_reached;
  logic [3:0] dose_count;

  int n_checks;
  int n_fail;
  int cyc;

  drug_delivery_controller dut (
    .clk                    (clk),
    .rst                    (rst),
    .drug_delivery_activate (drug_delivery_activate),
    .drug_dosage            (drug_dosage),
    .pump_ready             (pump_ready),
    .occlusion              (occlusion),
    .fault_clear            (fault_clear),
    .pump_step              (pump_step),
    .busy                   (busy),
    .dose_done              (dose_done),
    .fault                  (fault),
    .limit_reached          (limit_reached),
    .dose_count             (dose_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Fresh request edge: activate low for one edge, high for one edge, low.
  task automatic request(input logic [3:0] d);
    drug_delivery_activate = 1'b0;
    tick();
    drug_dosage            = d;
    drug_delivery_activate = 1'b1;
    tick();
    drug_delivery_activate = 1'b0;
  endtask

  task automatic watch(input int n, output int steps, output int dones, output int busy_hi);
    steps = 0; dones = 0; busy_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pump_step) steps++;
      if (dose_done) dones++;
      if (busy) busy_hi++;
    end
  endtask

  task automatic run_until_idle(input int bound, output int steps, output int dones, output bit to);
    steps = 0; dones = 0; to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (pump_step) steps++;
      if (dose_done) dones++;
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_steps(input int n, input int bound, output bit to);
    int seen;
    seen = 0; to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (pump_step) seen++;
      if (seen == n) begin to = 1'b0; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drug_delivery_activate = 1'b0; drug_dosage = 4'd0;
    pump_ready = 1'b1; occlusion = 1'b0; fault_clear = 1'b0;
    tick();
    tick();
    n_checks++; if (pump_step !== 1'b0) begin n_fail++; $display("FAIL reset_pump_step: got %b want 0", pump_step); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (dose_done !== 1'b0) begin n_fail++; $display("FAIL reset_dose_done: got %b want 0", dose_done); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_checks++; if (limit_reached !== 1'b0) begin n_fail++; $display("FAIL reset_limit: got %b want 0", limit_reached); end
    n_checks++; if (dose_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dose_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_dose();
    int t0, first, last, steps, dones, done_cyc, fall, bad_gap;
    steps = 0; dones = 0; done_cyc = -1; fall = -1; bad_gap = 0; first = -1; last = -1;
    pump_ready = 1'b1;
    request(4'd3);
    t0 = cyc;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dose1_busy_rise: got %b want 1", busy); end
    for (int i = 0; i < 300; i++) begin
      tick();
      if (pump_step) begin
        steps++;
        if (steps == 1) first = cyc;
        else if (cyc - last != 8) bad_gap++;
        last = cyc;
      end
      if (dose_done) begin dones++; done_cyc = cyc; end
      if (!busy) begin fall = cyc; break; end
    end
    n_checks++; if (steps !== 12) begin n_fail++; $display("FAIL dose1_steps: got %0d want 12", steps); end
    n_checks++; if (first - t0 !== 8) begin n_fail++; $display("FAIL dose1_first_latency: got %0d want 8", first - t0); end
    n_checks++; if (bad_gap !== 0) begin n_fail++; $display("FAIL dose1_spacing: got %0d bad gaps want 0", bad_gap); end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL dose1_done_pulses: got %0d want 1", dones); end
    n_checks++; if (done_cyc !== last) begin n_fail++; $display("FAIL dose1_done_with_last: got cycle %0d want %0d", done_cyc, last); end
    n_checks++; if (fall - last !== 64) begin n_fail++; $display("FAIL dose1_lockout_len: got %0d want 64", fall - last); end
    n_checks++; if (dose_count !== 4'd1) begin n_fail++; $display("FAIL dose1_count: got %0d want 1", dose_count); end
  endtask

  task automatic test_lockout_drop();
    int steps, dones, bh;
    bit to;
    request(4'd1);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dose_done) begin to = 1'b0; break; end
    end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL lock_dose_done_timeout: got timeout want done"); end
    repeat (5) tick();
    drug_dosage = 4'd2;
    drug_delivery_activate = 1'b1;
    run_until_idle(100, steps, dones, to);
    n_checks++; if (steps !== 0) begin n_fail++; $display("FAIL lock_edge_steps: got %0d want 0", steps); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL lock_end_timeout: got timeout want idle"); end
    watch(20, steps, dones, bh);
    n_checks++; if (steps + bh !== 0) begin n_fail++; $display("FAIL lock_held_level: got %0d steps/busy want 0", steps + bh); end
    n_checks++; if (dose_count !== 4'd2) begin n_fail++; $display("FAIL lock_count: got %0d want 2", dose_count); end
    request(4'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lock_new_edge_busy: got %b want 1", busy); end
    run_until_idle(200, steps, dones, to);
    n_checks++; if (steps !== 4 || dose_count !== 4'd3) begin n_fail++; $display("FAIL lock_new_dose: got steps %0d count %0d want 4 and 3", steps, dose_count); end
  endtask

  task automatic test_flow_control();
    int steps, dones, bh, total;
    bit to;
    logic [3:0] c0;
    c0 = dose_count;
    pump_ready = 1'b1;
    request(4'd2);
    wait_steps(2, 100, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL flow_two_steps_timeout: got timeout want 2 steps"); end
    pump_ready = 1'b0;
`ifdef DELIVERY_WATCHDOG_EN
    watch(38, steps, dones, bh);
    n_checks++; if (fault !== 1'b0 || steps !== 0) begin n_fail++; $display("FAIL wd_early: got fault %b steps %0d want 0 0", fault, steps); end
    tick();
    n_checks++; if (fault !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_trip: got fault %b busy %b want 1 0", fault, busy); end
    watch(1, steps, dones, bh);
    pump_ready = 1'b1;
    watch(10, steps, dones, bh);
    n_checks++; if (steps !== 0 || dose_count !== c0) begin n_fail++; $display("FAIL wd_after: got steps %0d count %0d want 0 %0d", steps, dose_count, c0); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got %b want 0", fault); end
`else
    watch(20, steps, dones, bh);
    n_checks++; if (steps !== 0 || bh !== 20) begin n_fail++; $display("FAIL flow_stall: got steps %0d busy %0d want 0 20", steps, bh); end
    pump_ready = 1'b1;
    tick();
    n_checks++; if (pump_step !== 1'b1) begin n_fail++; $display("FAIL flow_resume_step: got %b want 1", pump_step); end
    run_until_idle(300, steps, dones, to);
    total = 3 + steps;
    n_checks++; if (total !== 8) begin n_fail++; $display("FAIL flow_total_steps: got %0d want 8", total); end
    n_checks++; if (dones !== 1 || dose_count !== c0 + 4'd1) begin n_fail++; $display("FAIL flow_done: got dones %0d count %0d want 1 %0d", dones, dose_count, c0 + 4'd1); end
`endif
  endtask

  task automatic test_occlusion();
    int steps, dones, bh;
    bit to;
    logic [3:0] c0;
    c0 = dose_count;
    request(4'd4);
    wait_steps(5, 200, to);
    occlusion = 1'b1;
    tick();
    n_checks++; if (fault !== 1'b1 || busy !== 1'b0 || pump_step !== 1'b0) begin n_fail++; $display("FAIL occ_enter: got fault %b busy %b step %b want 1 0 0", fault, busy, pump_step); end
    watch(30, steps, dones, bh);
    n_checks++; if (steps !== 0 || dones !== 0 || dose_count !== c0) begin n_fail++; $display("FAIL occ_hold: got steps %0d dones %0d count %0d want 0 0 %0d", steps, dones, dose_count, c0); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL occ_clear_blocked: got %b want 1", fault); end
    occlusion = 1'b0;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    n_checks++; if (fault !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL occ_clear: got fault %b busy %b want 0 0", fault, busy); end
  endtask

  task automatic test_occlusion_last_step();
    bit to;
    logic [3:0] c0;
    c0 = dose_count;
    request(4'd1);
    wait_steps(3, 100, to);
    repeat (7) tick();
    occlusion = 1'b1;
    tick();
    n_checks++; if (pump_step !== 1'b0 || dose_done !== 1'b0) begin n_fail++; $display("FAIL occ_last_step: got step %b done %b want 0 0", pump_step, dose_done); end
    n_checks++; if (fault !== 1'b1 || dose_count !== c0) begin n_fail++; $display("FAIL occ_last_fault: got fault %b count %0d want 1 %0d", fault, dose_count, c0); end
    occlusion = 1'b0;
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
  endtask

  task automatic test_dose_limit();
    int steps, dones, bh, total, tos;
    bit to;
    do_reset();
    n_checks++; if (dose_count !== 4'd0) begin n_fail++; $display("FAIL limit_reset_count: got %0d want 0", dose_count); end
    request(4'd0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_dose_busy: got %b want 0", busy); end
    watch(20, steps, dones, bh);
    n_checks++; if (steps !== 0) begin n_fail++; $display("FAIL zero_dose_steps: got %0d want 0", steps); end
    total = 0; tos = 0;
    for (int d = 0; d < 8; d++) begin
      request(4'd1);
      run_until_idle(200, steps, dones, to);
      total += steps;
      if (to) tos++;
    end
    n_checks++; if (total !== 32 || tos !== 0) begin n_fail++; $display("FAIL limit_eight_doses: got steps %0d timeouts %0d want 32 0", total, tos); end
    n_checks++; if (dose_count !== 4'd8 || limit_reached !== 1'b1) begin n_fail++; $display("FAIL limit_flag: got count %0d limit %b want 8 1", dose_count, limit_reached); end
    request(4'd1);
    watch(40, steps, dones, bh);
    n_checks++; if (steps !== 0 || bh !== 0 || dose_count !== 4'd8) begin n_fail++; $display("FAIL limit_ninth: got steps %0d busy %0d count %0d want 0 0 8", steps, bh, dose_count); end
  endtask

  task automatic test_reset_mid_deliver();
    int steps, dones, bh;
    bit to;
    do_reset();
    request(4'd3);
    wait_steps(2, 100, to);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_checks++; if (pump_step !== 1'b0 || busy !== 1'b0 || dose_done !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got step %b busy %b done %b want 0 0 0", pump_step, busy, dose_done); end
    n_checks++; if (fault !== 1'b0 || dose_count !== 4'd0 || limit_reached !== 1'b0) begin n_fail++; $display("FAIL midrst_status: got fault %b count %0d limit %b want 0 0 0", fault, dose_count, limit_reached); end
    rst = 1'b0;
    watch(30, steps, dones, bh);
    n_checks++; if (steps !== 0 || dones !== 0 || bh !== 0) begin n_fail++; $display("FAIL midrst_after: got steps %0d dones %0d busy %0d want 0 0 0", steps, dones, bh); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_single_dose();
    test_lockout_drop();
    test_flow_control();
    test_occlusion();
    test_occlusion_last_step();
    test_dose_limit();
    test_reset_mid_deliver();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
